burst_seq_ctrl: RTL and testbench
=================================

# burst_seq_ctrl

Command-driven sequencer that sits directly upstream of the loadable up-counter (set has priority over count). It accepts a burst command (start value, beat count) over a valid/ready handshake and drives the counter's set/count controls. It reads the counter value back and presents it downstream as a valid/ready address stream with last-beat and done indications. One command is in flight at a time.

## Interface
- width, 8, counter/address width; must match the driven counter's width
- len_width, 8, beat-count width
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- i_cmd_valid  input  1  command valid
- o_cmd_ready  output  1  command ready; high only in IDLE with rst_n high
- i_cmd_start  input  width  first address of burst
- i_cmd_len  input  len_width  number of beats; 0 is a legal empty burst
- o_set_en  output  1  to counter set enable
- o_count_en  output  1  to counter count enable
- o_data  output  width  to counter load data
- i_number  input  width  counter value read back
- o_addr_valid  output  1  address beat valid
- i_addr_ready  input  1  downstream accepts beat
- o_addr  output  width  address beat, equal to i_number
- o_last  output  1  current beat is final beat of burst
- o_done  output  1  one-cycle pulse when a burst completes

## Operation
- States: IDLE, LOAD, RUN, DONE. Registered state; outputs decoded from state and registered fields.
- IDLE: o_cmd_ready=1. On i_cmd_valid&&o_cmd_ready, latch start into start_q and len into beats_q. Go to DONE if len==0, else go to LOAD.
- LOAD, one cycle: o_set_en=1, o_data=start_q. The counter loads at the end of this cycle. Go to RUN.
- RUN: o_addr_valid=1, o_addr=i_number, o_last=(beats_q==1).
  - On a beat handshake (o_addr_valid&&i_addr_ready): o_count_en=1 combinationally, and beats_q decrements.
  - If the handshake occurs with beats_q==1, go to DONE.
- DONE, one cycle: o_done=1. Go to IDLE.
- o_set_en and o_count_en are never high in the same cycle.
- o_data=start_q in all states; it is don't-care outside LOAD.
- o_addr is stable while valid is high and ready is low, because the counter only advances on o_count_en.
- Address arithmetic is modulo 2^width; wrap past all-ones to 0 is legal and not flagged.
- beats_q is len_width bits, and a beat count of 2^len_width-1 is supported.
- i_cmd_* is ignored outside IDLE. A command must be held until accepted.

## Timing
- Reset: state=IDLE. beats_q=0, start_q=0.
- Output values while rst_n is low: o_cmd_ready=0, o_set_en=0, o_count_en=0, o_addr_valid=0, o_last=0, o_done=0, o_data=0.
- The first cycle after reset release has o_cmd_ready=1.
- Command accepted in cycle N:
  - o_set_en high in N+1.
  - First beat valid in N+2 with o_addr=start.
- With i_addr_ready held high, there is one beat per cycle. The last beat is in N+1+len, o_done is in N+2+len, and the next command can be accepted in N+3+len.
- Empty burst (len==0): o_done in N+1, ready again in N+2, and no set or count pulses.
- Backpressure: each cycle with ready low holds the beat and delays all later events by one cycle.
- Reset asserted mid-burst: returns to IDLE next edge with no o_done. The counter value is left to the counter's own reset.

## Configuration
- BURST_ABORT_EN defined: adds input port i_abort (1 bit).
  - i_abort high in LOAD or RUN forces a transition to DONE at the next edge, with o_done pulsing as normal.
  - In an abort cycle, o_count_en is forced 0, and any beat handshake in that cycle is not counted. o_addr_valid stays high that cycle.
  - i_abort is ignored in IDLE and DONE.
- BURST_ABORT_EN undefined: no i_abort port; bursts always run to completion.

## Test plan
- Reset then cmd start=0x10, len=4, ready always 1:
  - set pulse, then addresses 0x10,0x11,0x12,0x13 on consecutive cycles.
  - o_last on 0x13, o_done one cycle after 0x13.
- Cmd start=0xFE, len=3: addresses 0xFE,0xFF,0x00, with o_last on 0x00.
- Cmd len=0: o_done exactly one cycle after acceptance, with no o_set_en, o_count_en or o_addr_valid.
- Cmd start=0x20, len=3 with ready toggling 1,0,0,1,0,1:
  - each address holds while ready is low.
  - exactly 3 count pulses and a sequence of 0x20,0x21,0x22.
- Back-to-back commands held valid: second accepted exactly 3+len cycles after the first, and no command accepted while busy.
- rst_n low during the second beat of a len=5 burst: next cycle is IDLE with all outputs at reset values and no o_done.
- With BURST_ABORT_EN, i_abort during beat 2 of len=6:
  - no o_count_en that cycle, and o_done next cycle.
  - exactly 1 count pulse in total.

Source files
------------

// File: rtl/burst_seq_ctrl.sv
// Burst command sequencer driving a loadable up-counter and streaming its value as addresses.
// Optional abort input enabled by defining BURST_ABORT_EN.
module burst_seq_ctrl #(
    parameter int unsigned width     = 8,
    parameter int unsigned len_width = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [width-1:0]     i_cmd_start,
    input  logic [len_width-1:0] i_cmd_len,
    output logic                 o_set_en,
    output logic                 o_count_en,
    output logic [width-1:0]     o_data,
    input  logic [width-1:0]     i_number,
    output logic                 o_addr_valid,
    input  logic                 i_addr_ready,
    output logic [width-1:0]     o_addr,
    output logic                 o_last,
    output logic                 o_done
`ifdef BURST_ABORT_EN
    ,
    input  logic                 i_abort
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [len_width-1:0] ONE_BEAT = len_width'(1);

    state_t               state, state_n;
    logic [len_width-1:0] beats_q, beats_n;
    logic [width-1:0]     start_q, start_n;

    logic cmd_ready;
    logic set_en;
    logic count_en;
    logic addr_valid;
    logic last;
    logic done;
    logic abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            beats_q <= '0;
            start_q <= '0;
        end else begin
            state   <= state_n;
            beats_q <= beats_n;
            start_q <= start_n;
        end
    end

    always_comb begin
        state_n    = state;
        beats_n    = beats_q;
        start_n    = start_q;
        cmd_ready  = 1'b0;
        set_en     = 1'b0;
        count_en   = 1'b0;
        addr_valid = 1'b0;
        last       = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
`ifdef BURST_ABORT_EN
        abort = i_abort && ((state == LOAD) || (state == RUN));
`endif

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    start_n = i_cmd_start;
                    beats_n = i_cmd_len;
                    state_n = (i_cmd_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                set_en  = 1'b1;
                state_n = abort ? DONE : RUN;
            end
            RUN: begin
                addr_valid = 1'b1;
                last       = (beats_q == ONE_BEAT);
                // An abort swallows any handshake in the same cycle.
                if (abort) begin
                    state_n = DONE;
                end else if (i_addr_ready) begin
                    count_en = 1'b1;
                    beats_n  = beats_q - ONE_BEAT;
                    if (beats_q == ONE_BEAT) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs forced low while reset is held, independent of the stored state.
    assign o_cmd_ready  = rst_n & cmd_ready;
    assign o_set_en     = rst_n & set_en;
    assign o_count_en   = rst_n & count_en;
    assign o_addr_valid = rst_n & addr_valid;
    assign o_last       = rst_n & last;
    assign o_done       = rst_n & done;
    assign o_data       = rst_n ? start_q : '0;
    assign o_addr       = i_number;

endmodule

// File: tb/tb_burst_seq_ctrl.sv
// Directed self-checking bench for burst_seq_ctrl with a behavioural loadable up-counter.
// Define BURST_ABORT_EN to include the abort scenario.
module tb_burst_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_start;
    logic [7:0] cmd_len;
    logic       set_en;
    logic       count_en;
    logic [7:0] data;
    logic [7:0] number;
    logic       addr_valid;
    logic       addr_ready;
    logic [7:0] addr;
    logic       last;
    logic       done;
`ifdef BURST_ABORT_EN
    logic       abort;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    int set_pulses   = 0;
    int count_pulses = 0;

    always #5 clk = ~clk;

    burst_seq_ctrl #(.width(8), .len_width(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_start  (cmd_start),
        .i_cmd_len    (cmd_len),
        .o_set_en     (set_en),
        .o_count_en   (count_en),
        .o_data       (data),
        .i_number     (number),
        .o_addr_valid (addr_valid),
        .i_addr_ready (addr_ready),
        .o_addr       (addr),
        .o_last       (last),
        .o_done       (done)
`ifdef BURST_ABORT_EN
        ,
        .i_abort      (abort)
`endif
    );

    // Downstream loadable up-counter; set wins over count.
    always @(posedge clk) begin
        if (!rst_n)        number <= 8'h00;
        else if (set_en)   number <= data;
        else if (count_en) number <= number + 8'h01;
    end

    always @(posedge clk) begin
        if (set_en)   set_pulses   <= set_pulses + 1;
        if (count_en) count_pulses <= count_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Accepts a command with ready held high and checks every cycle to the next idle.
    task automatic burst_ready(input logic [7:0] start, input logic [7:0] len, input string tag);
        logic [7:0] exp_addr;
        int sp0, cp0;
        cmd_valid  = 1'b1;
        cmd_start  = start;
        cmd_len    = len;
        addr_ready = 1'b1;
        #1;
        check_eq({tag, " accept_ready"}, cmd_ready, 1);
        next_cycle();
        sp0 = set_pulses;
        cp0 = count_pulses;
        cmd_valid = 1'b0;
        #1;
        if (len == 8'd0) begin
            check_eq({tag, " empty_done"}, done, 1);
            check_eq({tag, " empty_no_set"}, set_en, 0);
            check_eq({tag, " empty_no_valid"}, addr_valid, 0);
            check_eq({tag, " empty_no_count"}, count_en, 0);
        end else begin
            check_eq({tag, " load_set"}, set_en, 1);
            check_eq({tag, " load_data"}, data, start);
            check_eq({tag, " load_no_valid"}, addr_valid, 0);
            for (int i = 0; i < int'(len); i++) begin
                next_cycle();
                exp_addr = start + 8'(i);
                check_eq({tag, " beat_valid"}, addr_valid, 1);
                check_eq({tag, " beat_addr"}, addr, exp_addr);
                check_eq({tag, " beat_last"}, last, (i == int'(len) - 1) ? 1 : 0);
                check_eq({tag, " beat_count"}, count_en, 1);
                check_eq({tag, " beat_no_done"}, done, 0);
            end
            next_cycle();
            check_eq({tag, " done"}, done, 1);
            check_eq({tag, " done_no_valid"}, addr_valid, 0);
        end
        check_eq({tag, " busy_not_ready"}, cmd_ready, 0);
        next_cycle();
        check_eq({tag, " ready_again"}, cmd_ready, 1);
        check_eq({tag, " no_done_idle"}, done, 0);
        check_eq({tag, " set_pulses"}, set_pulses - sp0, (len == 8'd0) ? 0 : 1);
        check_eq({tag, " count_pulses"}, count_pulses - cp0, len);
    endtask

    initial begin
        logic [7:0] bp_ready;
        logic [7:0] bp_addr [6];
        logic [5:0] bp_last;
        logic [5:0] accepts;
        int cp0;

        rst_n      = 1'b0;
        cmd_valid  = 1'b1;
        cmd_start  = 8'h55;
        cmd_len    = 8'h03;
        addr_ready = 1'b1;
`ifdef BURST_ABORT_EN
        abort      = 1'b0;
`endif
        next_cycle();
        next_cycle();
        check_eq("rst cmd_ready", cmd_ready, 0);
        check_eq("rst set_en", set_en, 0);
        check_eq("rst count_en", count_en, 0);
        check_eq("rst addr_valid", addr_valid, 0);
        check_eq("rst last", last, 0);
        check_eq("rst done", done, 0);
        check_eq("rst data", data, 0);

        cmd_valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        #1;
        check_eq("post_rst ready", cmd_ready, 1);

        burst_ready(8'h10, 8'd4, "b1");
        burst_ready(8'hFE, 8'd3, "wrap");
        burst_ready(8'h77, 8'd0, "empty");

        // Backpressure: ready pattern 1,0,0,1,0,1 over the RUN cycles.
        bp_ready = 8'b0010_1001;
        bp_addr  = '{8'h20, 8'h21, 8'h21, 8'h21, 8'h22, 8'h22};
        bp_last  = 6'b110000;
        cmd_valid = 1'b1;
        cmd_start = 8'h20;
        cmd_len   = 8'd3;
        next_cycle();
        cmd_valid = 1'b0;
        cp0 = count_pulses;
        #1;
        check_eq("bp load_set", set_en, 1);
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            addr_ready = bp_ready[i];
            #1;
            check_eq("bp valid", addr_valid, 1);
            check_eq("bp addr", addr, bp_addr[i]);
            check_eq("bp last", last, bp_last[i]);
            check_eq("bp count_en", count_en, bp_ready[i]);
        end
        next_cycle();
        addr_ready = 1'b1;
        #1;
        check_eq("bp done", done, 1);
        check_eq("bp count_pulses", count_pulses - cp0, 3);
        next_cycle();

        // Back-to-back: command held valid; second acceptance 3+len cycles later.
        cmd_valid = 1'b1;
        cmd_start = 8'h40;
        cmd_len   = 8'd2;
        accepts   = '0;
        for (int c = 0; c < 6; c++) begin
            if (c != 0) next_cycle();
            #1;
            accepts[c] = cmd_ready;
        end
        check_eq("b2b accept_cycles", accepts, 6'b100001);
        next_cycle();
        cmd_valid = 1'b0;
        for (int c = 0; c < 3; c++) next_cycle();
        check_eq("b2b second_done", done, 1);
        next_cycle();
        check_eq("b2b idle", cmd_ready, 1);

        // Reset during the second beat of a len=5 burst.
        cmd_valid = 1'b1;
        cmd_start = 8'h30;
        cmd_len   = 8'd5;
        next_cycle();
        cmd_valid = 1'b0;
        next_cycle();
        next_cycle();
        check_eq("mid_rst beat2_addr", addr, 8'h31);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst valid_low", addr_valid, 0);
        check_eq("mid_rst count_low", count_en, 0);
        check_eq("mid_rst last_low", last, 0);
        next_cycle();
        rst_n = 1'b1;
        #1;
        check_eq("mid_rst idle_ready", cmd_ready, 1);
        check_eq("mid_rst no_done", done, 0);
        check_eq("mid_rst no_valid", addr_valid, 0);
        next_cycle();
        check_eq("mid_rst still_no_done", done, 0);

`ifdef BURST_ABORT_EN
        // Abort on beat 2 of a len=6 burst.
        cmd_valid  = 1'b1;
        cmd_start  = 8'h50;
        cmd_len    = 8'd6;
        addr_ready = 1'b1;
        next_cycle();
        cmd_valid = 1'b0;
        cp0 = count_pulses;
        next_cycle();
        check_eq("abort beat1_addr", addr, 8'h50);
        next_cycle();
        abort = 1'b1;
        #1;
        check_eq("abort no_count", count_en, 0);
        check_eq("abort valid_high", addr_valid, 1);
        next_cycle();
        abort = 1'b0;
        #1;
        check_eq("abort done", done, 1);
        check_eq("abort count_pulses", count_pulses - cp0, 1);
        next_cycle();
        check_eq("abort idle", cmd_ready, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule
